// File: rtl/astable_mac_sequencer.sv
// Time-shared MAC for the 555 astable control-voltage filter.
// Define ASTABLE_MAC_SATURATE_EN to clamp results instead of wrapping.
module astable_mac_sequencer #(
    parameter int DATA_W    = 25,
    parameter int COEF_W    = 18,
    parameter int COEF_FRAC = 17,
    parameter int C0        = 130782,
    parameter int C1        = 56,
    parameter int C2        = 165,
    parameter int C3        = 68
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic                     clear,
    input  logic signed [DATA_W-1:0] square_wave,
    input  logic signed [DATA_W-1:0] vcc,
    input  logic signed [DATA_W-1:0] walk_en,
    output logic signed [DATA_W-1:0] v_control,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun,
    output logic                     sat
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + 2;

    localparam logic signed [COEF_W-1:0] K0 = COEF_W'(C0);
    localparam logic signed [COEF_W-1:0] K1 = COEF_W'(C1);
    localparam logic signed [COEF_W-1:0] K2 = COEF_W'(C2);
    localparam logic signed [COEF_W-1:0] K3 = COEF_W'(C3);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        WRITE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                     accept;
    logic                     mac_en;
    logic                     wr_en;
    logic                     drop;
    logic [1:0]               idx;
    logic signed [DATA_W-1:0] op_state;
    logic signed [DATA_W-1:0] op_sq;
    logic signed [DATA_W-1:0] op_vcc;
    logic signed [DATA_W-1:0] op_walk;
    logic signed [DATA_W-1:0] op_sel;
    logic signed [COEF_W-1:0] coef_sel;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  term;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] res;
    logic signed [DATA_W-1:0] v_q;
    logic                     done_q;
    logic                     overrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (tick) state_nxt = MAC;
                MAC:     if (idx == 2'd3) state_nxt = WRITE;
                WRITE:   state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy   = (state != IDLE);
        accept = (state == IDLE) && tick && !clear;
        mac_en = (state == MAC) && !clear;
        wr_en  = (state == WRITE) && !clear;
        drop   = (state != IDLE) && tick && !clear;
    end

    always_comb begin
        coef_sel = K0;
        op_sel   = op_state;
        unique case (idx)
            2'd0: begin coef_sel = K0; op_sel = op_state; end
            2'd1: begin coef_sel = K1; op_sel = op_sq;    end
            2'd2: begin coef_sel = K2; op_sel = op_vcc;   end
            2'd3: begin coef_sel = K3; op_sel = op_walk;  end
        endcase
    end

    // Arithmetic shift floors toward -inf; the scaled term fits in ACC_W.
    assign prod = PROD_W'(coef_sel) * PROD_W'(op_sel);
    assign term = ACC_W'(prod >>> COEF_FRAC);

`ifdef ASTABLE_MAC_SATURATE_EN
    localparam logic signed [DATA_W-1:0] V_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] V_MIN = ~V_MAX;

    logic clamp;
    logic sat_q;

    always_comb begin
        clamp = 1'b0;
        res   = DATA_W'(acc);
        if (acc > ACC_W'(V_MAX)) begin
            clamp = 1'b1;
            res   = V_MAX;
        end else if (acc < ACC_W'(V_MIN)) begin
            clamp = 1'b1;
            res   = V_MIN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else if (wr_en && clamp) begin
            sat_q <= 1'b1;
        end
    end

    assign sat = sat_q;
`else
    assign res = DATA_W'(acc);
    assign sat = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            op_state  <= '0;
            op_sq     <= '0;
            op_vcc    <= '0;
            op_walk   <= '0;
            acc       <= '0;
            idx       <= '0;
            v_q       <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else if (clear) begin
            acc    <= '0;
            idx    <= '0;
            v_q    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= wr_en;
            if (drop) overrun_q <= 1'b1;
            if (accept) begin
                op_state <= v_q;
                op_sq    <= square_wave;
                op_vcc   <= vcc;
                op_walk  <= walk_en;
                acc      <= '0;
                idx      <= '0;
            end
            if (mac_en) begin
                acc <= acc + term;
                idx <= idx + 2'd1;
            end
            if (wr_en) v_q <= res;
        end
    end

    assign v_control = v_q;
    assign done      = done_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_astable_mac_sequencer.sv
// Directed bench for astable_mac_sequencer, default and clamp-test parameter sets.
// Honours ASTABLE_MAC_SATURATE_EN for the clamp-test expectations.
module tb_astable_mac_sequencer;

    localparam int DW = 25;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic tick;
    logic clear;
    logic signed [DW-1:0] square_wave;
    logic signed [DW-1:0] vcc;
    logic signed [DW-1:0] walk_en;
    logic signed [DW-1:0] v_control;
    logic busy;
    logic done;
    logic overrun;
    logic sat;

    logic tick2;
    logic signed [DW-1:0] in2;
    logic signed [DW-1:0] v2;
    logic busy2;
    logic done2;
    logic ov2;
    logic sat2;

    astable_mac_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .clear       (clear),
        .square_wave (square_wave),
        .vcc         (vcc),
        .walk_en     (walk_en),
        .v_control   (v_control),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun),
        .sat         (sat)
    );

    astable_mac_sequencer #(
        .C0 (0),
        .C1 (131071),
        .C2 (131071),
        .C3 (131071)
    ) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick2),
        .clear       (clear),
        .square_wave (in2),
        .vcc         (in2),
        .walk_en     (in2),
        .v_control   (v2),
        .busy        (busy2),
        .done        (done2),
        .overrun     (ov2),
        .sat         (sat2)
    );

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int d0;
    longint exp_v2;
    longint exp_s2;

    always @(negedge clk) if (done) done_cnt++;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; tick is sampled at the following posedge (T).
    task automatic pulse_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic run_sample(input string tag, input longint exp_v);
        wait_n(4);
        check({tag, ".busy4"}, busy, 1);
        check({tag, ".done4"}, done, 0);
        wait_n(1);
        check({tag, ".done5"}, done, 1);
        check({tag, ".busy5"}, busy, 0);
        check({tag, ".v"}, v_control, exp_v);
        wait_n(1);
        check({tag, ".done6"}, done, 0);
    endtask

    initial begin
        rst = 1'b1;
        tick = 1'b0;
        clear = 1'b0;
        square_wave = '0;
        vcc = '0;
        walk_en = '0;
        tick2 = 1'b0;
        in2 = 25'sd16777215;

        wait_n(3);
        check("rst.v", v_control, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.ovr", overrun, 0);
        check("rst.sat", sat, 0);
        rst = 1'b0;
        wait_n(1);

        d0 = done_cnt;
        for (int i = 0; i < 3; i++) begin
            pulse_tick();
            run_sample("zero", 0);
            wait_n(3);
        end
        check("zero.ndone", done_cnt - d0, 3);
        check("zero.ovr", overrun, 0);

        vcc = 25'sd131072;
        pulse_tick();
        run_sample("vcc1", 165);
        wait_n(2);
        pulse_tick();
        vcc = '0;
        run_sample("vcc2", 329);

        vcc = 25'sd131072;
        wait_n(2);
        pulse_tick();
        wait_n(1);
        clear = 1'b1;
        tick = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        tick = 1'b0;
        check("clr.v", v_control, 0);
        check("clr.busy", busy, 0);
        check("clr.done", done, 0);
        check("clr.ovr", overrun, 0);
        d0 = done_cnt;
        pulse_tick();
        run_sample("postclr", 165);
        wait_n(2);
        check("postclr.ndone", done_cnt - d0, 1);

        pulse_clear();
        check("clr2.v", v_control, 0);
        d0 = done_cnt;
        pulse_tick();
        wait_n(1);
        pulse_tick();
        check("drop.ovr", overrun, 1);
        check("drop.busy", busy, 1);
        wait_n(2);
        check("drop.done4", done, 0);
        wait_n(1);
        check("drop.done5", done, 1);
        check("drop.v", v_control, 165);
        wait_n(6);
        check("drop.ndone", done_cnt - d0, 1);

        pulse_tick();
        wait_n(2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst.v", v_control, 0);
        check("mrst.busy", busy, 0);
        check("mrst.done", done, 0);
        check("mrst.ovr", overrun, 0);
        check("mrst.sat", sat, 0);
        d0 = done_cnt;
        wait_n(6);
        check("mrst.ndone", done_cnt - d0, 0);
        check("mrst.v2", v_control, 0);

        pulse_tick();
        wait_n(4);
        pulse_tick();
        check("t5.done", done, 1);
        check("t5.v", v_control, 165);
        check("t5.ovr", overrun, 1);
        check("t5.busy", busy, 0);
        pulse_tick();
        check("t6.busy", busy, 1);
        run_sample("t6", 329);

        pulse_clear();
        vcc = -25'sd1;
        pulse_tick();
        run_sample("neg", -1);

        pulse_clear();
        square_wave = 25'sd131072;
        vcc = '0;
        walk_en = 25'sd262144;
        pulse_tick();
        run_sample("map", 192);
        check("main.sat", sat, 0);

`ifdef ASTABLE_MAC_SATURATE_EN
        exp_v2 = 16777215;
        exp_s2 = 1;
`else
        exp_v2 = 16776829;
        exp_s2 = 0;
`endif
        tick2 = 1'b1;
        @(negedge clk);
        tick2 = 1'b0;
        wait_n(4);
        check("sat.done4", done2, 0);
        wait_n(1);
        check("sat.done5", done2, 1);
        check("sat.v", v2, exp_v2);
        check("sat.flag", sat2, exp_s2);
        wait_n(2);
        check("sat.sticky", sat2, exp_s2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/astable_mac_sequencer.md
# astable_mac_sequencer

Time-multiplexed controller for the walk-enable 555 astable control-voltage filter. On each sample tick it sequences one shared signed multiplier through the four coefficient × operand products, accumulates them and updates the filter state register. This replaces four parallel constant multipliers plus an adder tree. It sits between the sample-rate strobe generator and the 555 comparator model that consumes `v_control`.

## Interface
- `DATA_W`, 25: width of all data operands, state and `v_control` (signed, common fixed-point format).
- `COEF_W`, 18: coefficient width (signed).
- `COEF_FRAC`, 17: coefficient fractional bits.
- `C0`, 130782: state feedback coefficient (≈0.99779).
- `C1`, 56: `square_wave` coefficient.
- `C2`, 165: `vcc` coefficient.
- `C3`, 68: `walk_en` coefficient.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `tick` in 1: sample strobe, one-cycle pulse.
- `clear` in 1: synchronous state clear and abort.
- `square_wave` in DATA_W: signed operand 1.
- `vcc` in DATA_W: signed operand 2.
- `walk_en` in DATA_W: signed operand 3.
- `v_control` out DATA_W: filter state (signed).
- `busy` out 1: a sample computation is in progress.
- `done` out 1: one-cycle pulse when `v_control` is updated.
- `overrun` out 1: sticky; a tick was dropped.
- `sat` out 1: sticky; the result was clamped.

## Operation
- States: IDLE, MAC, WRITE. A 2-bit index `idx` selects the (coefficient, operand) pair: 0 = (C0, state), 1 = (C1, square_wave), 2 = (C2, vcc), 3 = (C3, walk_en).
- IDLE with `tick`=1 and `clear`=0:
  - Latch the three inputs and the current state into operand registers.
  - Set acc to 0 and `idx` to 0.
  - Go to MAC.
- MAC, one product per cycle:
  - Compute the full-width product, DATA_W+COEF_W bits.
  - Arithmetic-shift it right by COEF_FRAC, which floors toward −∞.
  - Add the result into acc, which is DATA_W+2 bits signed.
  - Advance `idx`. After `idx`=3, go to WRITE.
- WRITE:
  - Reduce acc to DATA_W bits (see Configuration) and load it into the state register.
  - Pulse `done`.
  - Return to IDLE.
- Inputs that change after acceptance do not affect the sample in flight.
- `tick` while not in IDLE: the tick is dropped, `overrun` is set to 1, and the computation continues unaffected.
- `clear`:
  - Highest priority in every state.
  - State is set to 0, the FSM goes to IDLE, acc is discarded and no `done` is produced.
  - A same-cycle `tick` is ignored and does not set `overrun`.
  - `overrun` and `sat` are not affected.
- `rst` sets all outputs, including the sticky flags, and all internal registers to 0, and puts the FSM in IDLE. It aborts any in-flight sample.

## Timing
- Let T be the edge at which `tick` is sampled in IDLE.
- `busy` is 1 from edge T until edge T+5.
- Edges T+1 to T+4 perform the MAC steps for `idx` 0 to 3.
- At edge T+5, `v_control` takes the new value and `done` goes to 1 for exactly one cycle. `busy` is 0 after T+5.
- Minimum accepted tick spacing is 6 cycles. A tick at T+5 itself is dropped; a tick at T+6 is accepted.
- `v_control` is registered. There is no combinational path from any input to any output.

## Configuration
- `ASTABLE_MAC_SATURATE_EN`:
  - Defined: acc is clamped to [−2^(DATA_W−1), 2^(DATA_W−1)−1]. When clamping occurs, `sat` is set (sticky until `rst`).
  - Undefined: acc is truncated to its low DATA_W bits (two's-complement wrap) and `sat` is tied to 0.

## Test plan
- Reset, then hold all inputs at 0 and issue 3 ticks spaced 10 cycles apart → `v_control`=0 and 3 `done` pulses, each exactly 5 cycles after its tick. `overrun`=0.
- `vcc`=131072, other inputs 0, state 0, one tick → `v_control`=165 at T+5. A second tick gives 164+165=329.
- Ticks at T and T+2 → the second tick is dropped, `overrun`=1, `v_control`=165 (same stimulus as the previous test) with a single `done`.
- `v_control`=329, tick at T, `clear` at T+2 → `v_control`=0 after T+2, no `done`, `busy`=0 from T+3. A tick at T+3 is accepted normally.
- Parameters C1=C2=C3=131071, C0=0, all three inputs 16777215, one tick:
  - Macro defined → `v_control`=16777215, `sat`=1.
  - Macro undefined → `v_control`=16776829, `sat`=0.
- Assert `rst` at T+3 mid-sample → all outputs are 0 on the next cycle, the FSM is in IDLE and no `done` follows.
